i2s_transmitter: RTL

// - I2S bus master/serializer: generates bclk_o/lrclk_o and shifts out stereo PCM, MSB first.
// - Feeds the I2S receiver stage and the external codec DAC; bclk_o/lrclk_o are the shared bus clocks.
// - Accepts one L/R sample pair per frame over a valid/ready handshake from the audio datapath.

---
 rtl/i2s_pkg.sv | 29 ++
 rtl/i2s_transmitter_clkgen.sv | 90 +++++++++
 rtl/i2s_transmitter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel encoding, derived timing constants and
// parameter-legality rules common to the transmitter and receiver.
package i2s_pkg;

    // Word-select encoding on lrclk
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

    // clk cycles per bclk level (half a bclk period)
    function automatic logic [7:0] i2s_half_period(input logic [7:0] div);
        return div >> 1;
    endfunction

    // bclk periods per channel slot group (half a frame)
    function automatic logic [7:0] i2s_half_frame(input logic [7:0] frame_len);
        return frame_len >> 1;
    endfunction

    // Divider even and >= 4, frame even, each half wide enough for one word
    function automatic bit i2s_params_legal(input logic [7:0] div,
                                            input logic [7:0] word_len,
                                            input logic [7:0] frame_len);
        return (div >= 8'd4) && !div[0] && !frame_len[0] &&
               (word_len >= 8'd1) && ((frame_len >> 1) >= word_len);
    endfunction

endpackage

// File: rtl/i2s_transmitter_clkgen.sv
// I2S bus clock generator: divides clk_i down to bclk, counts bclk periods
// within the frame and drives lrclk. Exposes a one-cycle strobe for the
// edge on which bclk falls, together with the slot index entered there.
module i2s_transmitter_clkgen
    import i2s_pkg::*;
#(
    parameter logic [7:0] I2S_CLK_DIVISION    = 8'd14,
    parameter logic [7:0] I2S_AUDIO_FRAME_LEN = 8'd64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    output logic       bclk_o,
    output logic       lrclk_o,
    output logic       bclk_fall_o,
    output logic [7:0] slot_nxt_o
);

    localparam logic [7:0] HP_M1    = i2s_half_period(I2S_CLK_DIVISION) - 8'd1;
    localparam logic [7:0] HF       = i2s_half_frame(I2S_AUDIO_FRAME_LEN);
    localparam logic [7:0] FRAME_M1 = I2S_AUDIO_FRAME_LEN - 8'd1;

    logic [7:0] div_q, div_d;
    logic [7:0] slot_q, slot_d;
    logic       bclk_q, bclk_d;
    i2s_ch_e    lrclk_q, lrclk_d;
    // run_q low means no falling edge yet: the first fall enters slot 0
    logic       run_q, run_d;
    logic       fall;
    logic [7:0] slot_nxt;

    // Divider, slot counter and word select next-state
    always_comb begin
        div_d    = div_q;
        bclk_d   = bclk_q;
        slot_d   = slot_q;
        lrclk_d  = lrclk_q;
        run_d    = run_q;
        fall     = 1'b0;
        slot_nxt = slot_q;
        if (!enable_i) begin
            div_d   = 8'd0;
            bclk_d  = 1'b0;
            slot_d  = 8'd0;
            lrclk_d = CH_RIGHT;
            run_d   = 1'b0;
        end else begin
            if (div_q == HP_M1) begin
                div_d  = 8'd0;
                bclk_d = !bclk_q;
                fall   = bclk_q;
            end else begin
                div_d = div_q + 8'd1;
            end
            if (fall) begin
                if (!run_q || (slot_q == FRAME_M1)) begin
                    slot_nxt = 8'd0;
                end else begin
                    slot_nxt = slot_q + 8'd1;
                end
                slot_d  = slot_nxt;
                run_d   = 1'b1;
                lrclk_d = (slot_nxt >= HF) ? CH_RIGHT : CH_LEFT;
            end
        end
    end

    // Clock-generator state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q   <= 8'd0;
            slot_q  <= 8'd0;
            bclk_q  <= 1'b0;
            lrclk_q <= CH_RIGHT;
            run_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            slot_q  <= slot_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            run_q   <= run_d;
        end
    end

    assign bclk_o      = bclk_q;
    assign lrclk_o     = lrclk_q;
    assign bclk_fall_o = fall;
    assign slot_nxt_o  = slot_nxt;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S bus master / serializer. Generates bclk/lrclk and shifts out one
// stereo PCM pair per frame, MSB first with the standard one-bclk delay.
// Optional feature macro I2S_TX_REPEAT_ON_UNDERRUN_EN: when defined, a frame
// with no new pair re-sends the last transmitted pair instead of zeros.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter logic [7:0] I2S_CLK_DIVISION    = 8'd14,
    parameter logic [7:0] I2S_AUDIO_WORD_LEN  = 8'd24,
    parameter logic [7:0] I2S_AUDIO_FRAME_LEN = 8'd64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic [I2S_AUDIO_WORD_LEN-1:0] sample_left_i,
    input  logic [I2S_AUDIO_WORD_LEN-1:0] sample_right_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    output logic                          bclk_o,
    output logic                          lrclk_o,
    output logic                          audio_data_o,
    output logic                          underrun_o
);

    localparam int unsigned WL = I2S_AUDIO_WORD_LEN;
    localparam logic [7:0]  HF = i2s_half_frame(I2S_AUDIO_FRAME_LEN);

    if (!i2s_params_legal(I2S_CLK_DIVISION, I2S_AUDIO_WORD_LEN, I2S_AUDIO_FRAME_LEN)) begin : g_param_check
        $error("i2s_transmitter: illegal DIV/WORD/FRAME parameter combination");
    end

    logic       bclk_fall;
    logic [7:0] slot_nxt;
    logic       frame_start;
    logic       half_start;
    logic       xfer;

    i2s_transmitter_clkgen #(
        .I2S_CLK_DIVISION   (I2S_CLK_DIVISION),
        .I2S_AUDIO_FRAME_LEN(I2S_AUDIO_FRAME_LEN)
    ) u_clkgen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .enable_i   (enable_i),
        .bclk_o     (bclk_o),
        .lrclk_o    (lrclk_o),
        .bclk_fall_o(bclk_fall),
        .slot_nxt_o (slot_nxt)
    );

    logic          hold_valid_q, hold_valid_d;
    logic [WL-1:0] hold_left_q, hold_left_d;
    logic [WL-1:0] hold_right_q, hold_right_d;
    // tx_sr holds the word being serialized; its MSB is the next bit out
    logic [WL-1:0] tx_sr_q, tx_sr_d;
    logic [WL-1:0] right_sr_q, right_sr_d;
    logic          data_q, data_d;
    logic          underrun_q, underrun_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [WL-1:0] last_left_q, last_left_d;
    logic [WL-1:0] last_right_q, last_right_d;
`endif

    assign frame_start = bclk_fall && (slot_nxt == 8'd0);
    assign half_start  = bclk_fall && ((slot_nxt == 8'd0) || (slot_nxt == HF));
    // Ready depends only on registered state, never on sample_valid_i
    assign xfer        = sample_valid_i && !hold_valid_q;

    // Handshake, frame-start load and serializer next-state
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        tx_sr_d      = tx_sr_q;
        right_sr_d   = right_sr_q;
        data_d       = data_q;
        underrun_d   = 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        last_left_d  = last_left_q;
        last_right_d = last_right_q;
`endif
        if (xfer) begin
            hold_valid_d = 1'b1;
            hold_left_d  = sample_left_i;
            hold_right_d = sample_right_i;
        end
        if (!enable_i) begin
            tx_sr_d    = '0;
            right_sr_d = '0;
            data_d     = 1'b0;
        end else if (bclk_fall) begin
            // The bit leaving now is the one left over from the previous
            // slot, which yields the one-bclk delay and, when the word fills
            // the whole half, the LSB at position 0 of the next half.
            data_d = tx_sr_q[WL-1];
            if (frame_start) begin
                if (hold_valid_q) begin
                    tx_sr_d      = hold_left_q;
                    right_sr_d   = hold_right_q;
                    hold_valid_d = 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                    last_left_d  = hold_left_q;
                    last_right_d = hold_right_q;
`endif
                end else begin
                    underrun_d = 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                    tx_sr_d    = last_left_q;
                    right_sr_d = last_right_q;
`else
                    tx_sr_d    = '0;
                    right_sr_d = '0;
`endif
                end
            end else if (half_start) begin
                tx_sr_d = right_sr_q;
            end else begin
                tx_sr_d = tx_sr_q << 1;
            end
        end
    end

    // Datapath and handshake registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            tx_sr_q      <= '0;
            right_sr_q   <= '0;
            data_q       <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            last_left_q  <= '0;
            last_right_q <= '0;
`endif
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            tx_sr_q      <= tx_sr_d;
            right_sr_q   <= right_sr_d;
            data_q       <= data_d;
            underrun_q   <= underrun_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            last_left_q  <= last_left_d;
            last_right_q <= last_right_d;
`endif
        end
    end

    assign sample_ready_o = !hold_valid_q;
    assign audio_data_o   = data_q;
    assign underrun_o     = underrun_q;

endmodule
